multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Multi-cycle RV32I control sequencer. Walks FETCH/DECODE/EXEC/MEM/WB per
//  instruction; handshakes with instruction and data memories (variable wait
//  states) and emits per-state datapath controls. Same encodings as the
//  single-cycle decoder; adds bus-timeout fault and retired-instruction count.
// PARAMETERS
//  MEM_TIMEOUT  16  cycles a memory request may wait for ready before fault (>=2)
//  INSTRET_W    32  width of retired-instruction counter
// PORTS
//  clk         in   1          clock, rising edge
//  rst_n       in   1          async active-low reset
//  opcode      in   7          instr[6:0] from fetch bus, sampled when ir_write=1
//  imem_ready  in   1          instruction word valid this cycle
//  dmem_ready  in   1          data access complete this cycle
//  imem_req    out  1          fetch request, held until imem_ready
//  dmem_req    out  1          data request, held until dmem_ready
//  ir_write    out  1          load instruction register (1-cycle pulse)
//  pc_write    out  1          update PC from pc_src mux (1-cycle pulse)
//  mem_read    out  1          data read (with dmem_req)
//  mem_write   out  1          data write (with dmem_req)
//  reg_write   out  1          register file write enable (1-cycle pulse)
//  alu_src     out  1          0=rs2, 1=immediate
//  alu_op      out  2          00 add,01 branch,10 I-arith,11 R-arith
//  pc_src      out  2          00 pc+4,01 branch,10 jal,11 jalr
//  mem_to_reg  out  3          000 alu,001 mem,010 pc+4,011 u-imm,100 pc+u-imm
//  instret     out  INSTRET_W  retired-instruction count
//  bus_err     out  1          sticky: memory timeout occurred
//  state_o     out  3          current state (debug)
// BEHAVIOUR
//  States: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 FAULT=6.
//  Reset: state=IDLE, opcode_q=0, wait_cnt=0, instret=0, bus_err=0; all
//   control outputs 0. IDLE -> FETCH unconditionally next cycle.
//  Outputs combinational from (state, opcode_q); 0 in states not listed.
//  FETCH: imem_req=1; on imem_ready: ir_write=1, opcode_q<=opcode, ->DECODE.
//  DECODE: 1 cycle, no outputs asserted, ->EXEC.
//  EXEC: alu_src/alu_op per class (R:0/11, I:1/10, load/store:1/00,
//   branch:0/01, jalr:1/00, others 0/00).
//   branch: pc_write=1,pc_src=01 (PC logic gates with compare) ->FETCH.
//   jal: reg_write=1,mem_to_reg=010,pc_write=1,pc_src=10 ->FETCH.
//   jalr: same with pc_src=11 ->FETCH.   load/store ->MEM.  R/I/lui/auipc ->WB.
//  MEM: dmem_req=1, mem_read (load) or mem_write (store), alu_src=1.
//   On dmem_ready: load ->WB; store: pc_write=1,pc_src=00 ->FETCH.
//  WB: reg_write=1, pc_write=1, pc_src=00; mem_to_reg R/I=000, load=001,
//   lui=011, auipc=100 ->FETCH.
//  Latency (zero-wait memory): branch/jal/jalr 3, R/I/lui/auipc/store 4,
//   load 5 cycles FETCH-entry to FETCH-entry.
//  instret: +1 on every cycle pc_write=1; wraps 2^INSTRET_W-1 -> 0.
//  wait_cnt: cleared on entry to FETCH/MEM and on ready; increments each
//   FETCH/MEM cycle with ready low. When wait_cnt==MEM_TIMEOUT-1 and ready
//   still low: bus_err<=1, ->FAULT. Ready in that same cycle wins (no fault).
//  FAULT: all controls 0, no requests; left only by reset.
//  ready while req=0 ignored. Reset mid-MEM aborts access; no write retire.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: extra output illegal (1 bit, sticky, reset 0).
//   Opcode outside {3,19,23,35,51,55,99,103,111} in EXEC: illegal<=1,
//   ->FAULT, no pc_write, instret unchanged.
//  Undefined: unknown opcode in EXEC acts as NOP: pc_write=1,pc_src=00,
//   ->FETCH, instret+1; no reg/mem write. Port illegal absent.
// TESTING
//  R-type 51, ready always 1 -> reg_write+pc_write in 4th cycle, instret=1.
//  load 3, dmem_ready after 3 wait cycles -> dmem_req 4 cycles, WB mem_to_reg=001.
//  MEM_TIMEOUT=8, imem_ready=0 -> bus_err=1 at 8th FETCH cycle, state_o=6.
//  rst_n low mid-MEM of store -> outputs 0 async, mem_write never completes.
//  opcode 7'h7F: macro on -> illegal=1,FAULT; off -> NOP, instret+1.
//  INSTRET_W=4, 16 jal's -> instret wraps 15->0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory wait
// states, bus-timeout fault and retired-instruction counter. Optional macro: ILLEGAL_TRAP_EN.
module multicycle_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 imem_req,
    output logic                 dmem_req,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic                 alu_src,
    output logic [1:0]           alu_op,
    output logic [1:0]           pc_src,
    output logic [2:0]           mem_to_reg,
    output logic [INSTRET_W-1:0] instret,
    output logic                 bus_err,
`ifdef ILLEGAL_TRAP_EN
    output logic                 illegal,
`endif
    output logic [2:0]           state_o
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT) + 1;

    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_IMM    = 7'd19;
    localparam logic [6:0] OP_AUIPC  = 7'd23;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_REG    = 7'd51;
    localparam logic [6:0] OP_LUI    = 7'd55;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JALR   = 7'd103;
    localparam logic [6:0] OP_JAL    = 7'd111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic [6:0]             opcode_q, opcode_d;
    logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [INSTRET_W-1:0]   instret_q, instret_d;
    logic                   bus_err_q, bus_err_d;
`ifdef ILLEGAL_TRAP_EN
    logic                   illegal_q, illegal_d;
`endif

    logic timeout_hit;
    assign timeout_hit = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));

    // State and bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            opcode_q   <= '0;
            wait_cnt_q <= '0;
            instret_q  <= '0;
            bus_err_q  <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            wait_cnt_q <= wait_cnt_d;
            instret_q  <= instret_d;
            bus_err_q  <= bus_err_d;
`ifdef ILLEGAL_TRAP_EN
            illegal_q  <= illegal_d;
`endif
        end
    end

    // Next-state and per-state datapath controls
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        wait_cnt_d = '0;
        bus_err_d  = bus_err_q;
`ifdef ILLEGAL_TRAP_EN
        illegal_d  = illegal_q;
`endif
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        mem_to_reg = 3'b000;

        case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    opcode_d = opcode;
                    state_d  = S_DECODE;
                end else if (timeout_hit) begin
                    bus_err_d = 1'b1;
                    state_d   = S_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            S_DECODE: state_d = S_EXEC;

            S_EXEC: begin
                case (opcode_q)
                    OP_LOAD, OP_STORE: begin
                        alu_src = 1'b1;
                        state_d = S_MEM;
                    end
                    OP_REG: begin
                        alu_op  = 2'b11;
                        state_d = S_WB;
                    end
                    OP_IMM: begin
                        alu_src = 1'b1;
                        alu_op  = 2'b10;
                        state_d = S_WB;
                    end
                    OP_LUI, OP_AUIPC: state_d = S_WB;
                    OP_BRANCH: begin
                        alu_op   = 2'b01;
                        pc_write = 1'b1;
                        pc_src   = 2'b01;
                        state_d  = S_FETCH;
                    end
                    OP_JAL: begin
                        reg_write  = 1'b1;
                        mem_to_reg = 3'b010;
                        pc_write   = 1'b1;
                        pc_src     = 2'b10;
                        state_d    = S_FETCH;
                    end
                    OP_JALR: begin
                        alu_src    = 1'b1;
                        reg_write  = 1'b1;
                        mem_to_reg = 3'b010;
                        pc_write   = 1'b1;
                        pc_src     = 2'b11;
                        state_d    = S_FETCH;
                    end
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        illegal_d = 1'b1;
                        state_d   = S_FAULT;
`else
                        // Unknown opcode retires as a NOP
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
`endif
                    end
                endcase
            end

            S_MEM: begin
                dmem_req  = 1'b1;
                alu_src   = 1'b1;
                mem_read  = (opcode_q == OP_LOAD);
                mem_write = (opcode_q == OP_STORE);
                if (dmem_ready) begin
                    if (opcode_q == OP_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                end else if (timeout_hit) begin
                    bus_err_d = 1'b1;
                    state_d   = S_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                case (opcode_q)
                    OP_LOAD:  mem_to_reg = 3'b001;
                    OP_LUI:   mem_to_reg = 3'b011;
                    OP_AUIPC: mem_to_reg = 3'b100;
                    default:  mem_to_reg = 3'b000;
                endcase
                state_d = S_FETCH;
            end

            S_FAULT: state_d = S_FAULT;

            default: state_d = S_IDLE;
        endcase

        instret_d = pc_write ? instret_q + INSTRET_W'(1) : instret_q;
    end

    assign instret = instret_q;
    assign bus_err = bus_err_q;
    assign state_o = state_q;
`ifdef ILLEGAL_TRAP_EN
    assign illegal = illegal_q;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed, table-driven bench for multicycle_control_fsm (MEM_TIMEOUT=8, INSTRET_W=4).
module tb_multicycle_control_fsm;

    localparam int unsigned MEM_TIMEOUT = 8;
    localparam int unsigned INSTRET_W   = 4;

    logic                 clk;
    logic                 rst_n;
    logic [6:0]           opcode;
    logic                 imem_ready;
    logic                 dmem_ready;
    logic                 imem_req;
    logic                 dmem_req;
    logic                 ir_write;
    logic                 pc_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 reg_write;
    logic                 alu_src;
    logic [1:0]           alu_op;
    logic [1:0]           pc_src;
    logic [2:0]           mem_to_reg;
    logic [INSTRET_W-1:0] instret;
    logic                 bus_err;
    logic [2:0]           state_o;
`ifdef ILLEGAL_TRAP_EN
    logic                 illegal;
`endif

    int checks;
    int failures;
    logic [INSTRET_W-1:0] exp_instret;

    multicycle_control_fsm #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .INSTRET_W  (INSTRET_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .imem_ready(imem_ready),
        .dmem_ready(dmem_ready),
        .imem_req  (imem_req),
        .dmem_req  (dmem_req),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .reg_write (reg_write),
        .alu_src   (alu_src),
        .alu_op    (alu_op),
        .pc_src    (pc_src),
        .mem_to_reg(mem_to_reg),
        .instret   (instret),
        .bus_err   (bus_err),
`ifdef ILLEGAL_TRAP_EN
        .illegal   (illegal),
`endif
        .state_o   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] op;
        logic       alu_src;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic [2:0] m2r;
        logic       rw;
        logic       mr;
        logic       mw;
        logic [3:0] lat;
    } vec_t;

    typedef struct {
        int lat;
        int alu_src;
        int alu_op;
        int pc_src;
        int m2r;
        int rw_cnt;
        int pcw_cnt;
        int mr;
        int mw;
        int dreq_cnt;
    } obs_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one instruction from a negedge in FETCH until the next FETCH entry (or FAULT)
    task automatic run_instr(input logic [6:0] op, input int iwait, input int dwait,
                             output obs_t o);
        int  fetch_n;
        int  mem_n;
        bit  left;
        o       = '{default: 0};
        fetch_n = 0;
        mem_n   = 0;
        left    = 1'b0;
        opcode  = op;
        while (1) begin
            if (state_o != 3'd1) left = 1'b1;
            if ((left && state_o == 3'd1) || state_o == 3'd6 || o.lat >= 60) break;
            imem_ready = (state_o == 3'd1) && (fetch_n == iwait);
            dmem_ready = (state_o == 3'd4) && (mem_n == dwait);
            if (state_o == 3'd1) fetch_n++;
            if (state_o == 3'd4) mem_n++;
            #1;
            o.lat++;
            if (state_o == 3'd3) begin
                o.alu_src = int'(alu_src);
                o.alu_op  = int'(alu_op);
            end
            if (pc_write) begin
                o.pcw_cnt++;
                o.pc_src = int'(pc_src);
                o.m2r    = int'(mem_to_reg);
            end
            if (reg_write) o.rw_cnt++;
            if (mem_read)  o.mr = 1;
            if (mem_write) o.mw = 1;
            if (dmem_req)  o.dreq_cnt++;
            @(negedge clk);
        end
    endtask

    vec_t vecs[$];
    obs_t o;
    logic [INSTRET_W-1:0] prev;
    bit seen_wrap;

    initial begin
        checks      = 0;
        failures    = 0;
        exp_instret = '0;
        seen_wrap   = 1'b0;

        // opcode, alu_src, alu_op, pc_src, mem_to_reg, reg_write, mem_read, mem_write, latency
        vecs.push_back('{7'd51,  1'b0, 2'b11, 2'b00, 3'b000, 1'b1, 1'b0, 1'b0, 4'd4});
        vecs.push_back('{7'd19,  1'b1, 2'b10, 2'b00, 3'b000, 1'b1, 1'b0, 1'b0, 4'd4});
        vecs.push_back('{7'd3,   1'b1, 2'b00, 2'b00, 3'b001, 1'b1, 1'b1, 1'b0, 4'd5});
        vecs.push_back('{7'd35,  1'b1, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 4'd4});
        vecs.push_back('{7'd99,  1'b0, 2'b01, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 4'd3});
        vecs.push_back('{7'd111, 1'b0, 2'b00, 2'b10, 3'b010, 1'b1, 1'b0, 1'b0, 4'd3});
        vecs.push_back('{7'd103, 1'b1, 2'b00, 2'b11, 3'b010, 1'b1, 1'b0, 1'b0, 4'd3});
        vecs.push_back('{7'd55,  1'b0, 2'b00, 2'b00, 3'b011, 1'b1, 1'b0, 1'b0, 4'd4});
        vecs.push_back('{7'd23,  1'b0, 2'b00, 2'b00, 3'b100, 1'b1, 1'b0, 1'b0, 4'd4});
`ifndef ILLEGAL_TRAP_EN
        vecs.push_back('{7'h7F,  1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 4'd3});
`endif

        rst_n      = 1'b0;
        opcode     = '0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #3;
        chk("rst_state", int'(state_o), 0);
        chk("rst_imem_req", int'(imem_req), 0);
        chk("rst_pc_write", int'(pc_write), 0);
        chk("rst_instret", int'(instret), 0);
        chk("rst_bus_err", int'(bus_err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_state", int'(state_o), 0);
        @(negedge clk);
        chk("idle_to_fetch", int'(state_o), 1);
        chk("fetch_imem_req", int'(imem_req), 1);

        foreach (vecs[i]) begin
            run_instr(vecs[i].op, 0, 0, o);
            exp_instret = exp_instret + INSTRET_W'(1);
            chk($sformatf("op%0d_lat", vecs[i].op), o.lat, int'(vecs[i].lat));
            chk($sformatf("op%0d_alu_src", vecs[i].op), o.alu_src, int'(vecs[i].alu_src));
            chk($sformatf("op%0d_alu_op", vecs[i].op), o.alu_op, int'(vecs[i].alu_op));
            chk($sformatf("op%0d_pc_src", vecs[i].op), o.pc_src, int'(vecs[i].pc_src));
            chk($sformatf("op%0d_mem_to_reg", vecs[i].op), o.m2r, int'(vecs[i].m2r));
            chk($sformatf("op%0d_reg_write", vecs[i].op), o.rw_cnt, int'(vecs[i].rw));
            chk($sformatf("op%0d_mem_read", vecs[i].op), o.mr, int'(vecs[i].mr));
            chk($sformatf("op%0d_mem_write", vecs[i].op), o.mw, int'(vecs[i].mw));
            chk($sformatf("op%0d_pc_write_cnt", vecs[i].op), o.pcw_cnt, 1);
            chk($sformatf("op%0d_instret", vecs[i].op), int'(instret), int'(exp_instret));
        end

        // Load with three data wait states
        run_instr(7'd3, 0, 3, o);
        exp_instret = exp_instret + INSTRET_W'(1);
        chk("ld_wait_dmem_req_cycles", o.dreq_cnt, 4);
        chk("ld_wait_mem_to_reg", o.m2r, 1);
        chk("ld_wait_lat", o.lat, 8);
        chk("ld_wait_instret", int'(instret), int'(exp_instret));

        // Ready arriving on the last allowed fetch cycle beats the timeout
        run_instr(7'd51, 7, 0, o);
        exp_instret = exp_instret + INSTRET_W'(1);
        chk("fetch_edge_lat", o.lat, 11);
        chk("fetch_edge_bus_err", int'(bus_err), 0);
        chk("fetch_edge_instret", int'(instret), int'(exp_instret));

        run_instr(7'd3, 0, 7, o);
        exp_instret = exp_instret + INSTRET_W'(1);
        chk("mem_edge_lat", o.lat, 12);
        chk("mem_edge_bus_err", int'(bus_err), 0);
        chk("mem_edge_instret", int'(instret), int'(exp_instret));

        // Sixteen jal's wrap the 4-bit counter
        for (int k = 0; k < 16; k++) begin
            prev = instret;
            run_instr(7'd111, 0, 0, o);
            exp_instret = exp_instret + INSTRET_W'(1);
            chk($sformatf("jal%0d_instret", k), int'(instret), int'(exp_instret));
            if (prev == 4'd15) begin
                chk("instret_wrap", int'(instret), 0);
                seen_wrap = 1'b1;
            end
        end
        chk("instret_wrap_seen", int'(seen_wrap), 1);

        // Reset in the middle of a store's data access
        opcode     = 7'd35;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        for (int k = 0; k < 10 && state_o != 3'd4; k++) @(negedge clk);
        chk("st_in_mem", int'(state_o), 4);
        chk("st_mem_write", int'(mem_write), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("st_rst_state", int'(state_o), 0);
        chk("st_rst_mem_write", int'(mem_write), 0);
        chk("st_rst_dmem_req", int'(dmem_req), 0);
        chk("st_rst_instret", int'(instret), 0);
        dmem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("st_after_rst_state", int'(state_o), 1);
        chk("st_after_rst_instret", int'(instret), 0);
        chk("st_after_rst_mem_write", int'(mem_write), 0);

        // Fetch timeout: imem_ready never arrives
        dmem_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            imem_ready = 1'b0;
            #1;
            chk($sformatf("to_cycle%0d_state", k), int'(state_o), 1);
            chk($sformatf("to_cycle%0d_bus_err", k), int'(bus_err), 0);
            @(negedge clk);
        end
        chk("to_fault_state", int'(state_o), 6);
        chk("to_bus_err", int'(bus_err), 1);
        chk("to_imem_req", int'(imem_req), 0);
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("fault_sticky_state", int'(state_o), 6);
        chk("fault_sticky_bus_err", int'(bus_err), 1);
        chk("fault_pc_write", int'(pc_write), 0);
        chk("fault_instret", int'(instret), 0);

`ifdef ILLEGAL_TRAP_EN
        rst_n = 1'b0;
        #1;
        chk("ill_rst_illegal", int'(illegal), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_instr(7'h7F, 0, 0, o);
        chk("ill_state", int'(state_o), 6);
        chk("ill_flag", int'(illegal), 1);
        chk("ill_pc_write_cnt", o.pcw_cnt, 0);
        chk("ill_instret", int'(instret), 0);
        chk("ill_bus_err", int'(bus_err), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
